// File: rtl/exe_wb_pipe.sv
// -----------------------------------------------------------------------------
// exe_wb_pipe
//   Execute-to-writeback pipeline stage. It is a 2-entry in-order skid buffer
//   that holds ALU result beats until the writeback stage takes them.
//
//   Handshake: a beat moves across an interface on a rising edge where both
//   valid and ready are high. The upstream side also requires flush_i to be
//   low. in_ready_o and out_valid_o depend only on registered state, so there
//   is no combinational path from either input handshake to either output.
//
//   Ports
//     clk, n_reset             clock, asynchronous active-low reset
//     in_valid_i / in_ready_o  upstream handshake
//     result_i, jump_now_i,    beat payload from the ALU
//     is_branch_i, wen_i,
//     rd_addr_i
//     flush_i                  drop held beats and the incoming beat
//     out_valid_o/out_ready_i  downstream handshake
//     result_o, jump_now_o,    head-beat payload (all zero when empty)
//     wen_o, rd_addr_o
//     stall_cnt_o              saturating count of upstream stall cycles
//     state_dbg_o              current buffer state (EMPTY/ONE/TWO)
// -----------------------------------------------------------------------------
module exe_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] result_i,
  input  logic              jump_now_i,
  input  logic              is_branch_i,
  input  logic              wen_i,
  input  logic [RA_W-1:0]   rd_addr_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              jump_now_o,
  output logic              wen_o,
  output logic [RA_W-1:0]   rd_addr_o,
  output logic [15:0]       stall_cnt_o,
  output logic [1:0]        state_dbg_o
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              jump;
    logic              wen;
    logic [RA_W-1:0]   rd;
  } entry_t;

  logic [1:0]  state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  entry_t in_beat;
  logic   accept;
  logic   release_beat;

  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);

  assign accept       = in_valid_i && in_ready_o && !flush_i;
  assign release_beat = out_valid_o && out_ready_i;

  // Scrub the payload on capture: the ALU may leave jump_now undefined on
  // non-branch beats, and register 0 must never be written.
  always_comb begin
    in_beat        = '0;
    in_beat.result = result_i;
    in_beat.jump   = is_branch_i & jump_now_i;
    in_beat.wen    = wen_i && (rd_addr_i != '0);
    in_beat.rd     = rd_addr_i;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;

    if (flush_i) begin
      // A release in this same cycle still counts as consumed downstream;
      // everything left over is simply discarded.
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({accept, release_beat})
            2'b10: begin
              tail_d  = in_beat;
              state_d = TWO;
            end
            2'b01: begin
              head_d  = '0;
              state_d = EMPTY;
            end
            2'b11: begin
              // Head leaves and the new beat takes its place directly.
              head_d  = in_beat;
              state_d = ONE;
            end
            default: begin
              state_d = ONE;
            end
          endcase
        end
        TWO: begin
          // No accept is possible here (in_ready_o is low).
          if (release_beat) begin
            head_d  = tail_q;
            tail_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty buffer.
          state_d = EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  // Upstream stall counter; deliberately unaffected by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid_i && !in_ready_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign result_o    = out_valid_o ? head_q.result : '0;
  assign jump_now_o  = out_valid_o ? head_q.jump   : 1'b0;
  assign wen_o       = out_valid_o ? head_q.wen    : 1'b0;
  assign rd_addr_o   = out_valid_o ? head_q.rd     : '0;
  assign stall_cnt_o = stall_cnt_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_exe_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_exe_wb_pipe
//   Self-checking bench for exe_wb_pipe. A reference model holds the buffered
//   beats as a plain FIFO queue (max two entries) plus an integer stall count;
//   DUT outputs are compared to it one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_exe_wb_pipe;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int EW     = DATA_W + 2 + RA_W;   // {result, jump, wen, rd}
  localparam int OW     = 2 + EW + 16;         // {valid, ready, entry, stall}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DATA_W-1:0] result_i = '0;
  logic              jump_now_i = 1'b0;
  logic              is_branch_i = 1'b0;
  logic              wen_i = 1'b0;
  logic [RA_W-1:0]   rd_addr_i = '0;
  logic              flush_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [DATA_W-1:0] result_o;
  logic              jump_now_o;
  logic              wen_o;
  logic [RA_W-1:0]   rd_addr_o;
  logic [15:0]       stall_cnt_o;
  logic [1:0]        state_dbg_o;

  exe_wb_pipe #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .result_i   (result_i),
    .jump_now_i (jump_now_i),
    .is_branch_i(is_branch_i),
    .wen_i      (wen_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .jump_now_o (jump_now_o),
    .wen_o      (wen_o),
    .rd_addr_o  (rd_addr_o),
    .stall_cnt_o(stall_cnt_o),
    .state_dbg_o(state_dbg_o)
  );

  logic [OW-1:0] obs;
  assign obs = {out_valid_o, in_ready_o, result_o, jump_now_o, wen_o,
                rd_addr_o, stall_cnt_o};

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  int stall_m = 0;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [OW-1:0] exp_vec();
    logic [EW-1:0] e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q[0];
    return {exp_q.size() != 0, exp_q.size() < 2, e, 16'(stall_m)};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    stall_m = 0;
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs, waits for the edge, then advances the model.
  task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] res,
                             input logic jn, input logic br, input logic we,
                             input logic [RA_W-1:0] rd, input logic ordy,
                             input logic fl);
    logic acc, rel, jm, wm;
    in_valid_i  = v;
    result_i    = res;
    jump_now_i  = jn;
    is_branch_i = br;
    wen_i       = we;
    rd_addr_i   = rd;
    out_ready_i = ordy;
    flush_i     = fl;
    acc = v && (exp_q.size() < 2) && !fl;
    rel = (exp_q.size() > 0) && ordy;
    if (v && exp_q.size() == 2 && stall_m < 65535) stall_m++;
    jm = br ? jn : 1'b0;
    wm = (rd == 0) ? 1'b0 : we;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rel) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({res, jm, wm, rd});
    end
  endtask

  task automatic idle_cycle(input logic ordy);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, ordy, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    n_reset = 1'b0;
    model_reset();
    #12;
    vectors++;
    if (obs !== exp_vec() || state_dbg_o !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h st=%0d want %h st=0", obs, state_dbg_o, exp_vec());
    end
    @(posedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  task automatic test_single_beat;
    drive_cycle(1'b1, 32'h0000_00AA, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    vectors++;
    if (out_valid_o !== 1'b1 || result_o !== 32'hAA || rd_addr_o !== 5'd3 ||
        wen_o !== 1'b1 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL single_beat_out: got v=%b r=%h rd=%0d w=%b want v=1 r=aa rd=3 w=1",
               out_valid_o, result_o, rd_addr_o, wen_o);
    end
    idle_cycle(1'b1);
    vectors++;
    if (out_valid_o !== 1'b0 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL single_beat_drain: got v=%b want v=0", out_valid_o);
    end
  endtask

  task automatic test_backpressure;
    logic [DATA_W-1:0] want[3];
    int seen;
    logic c_in;
    want[0] = 32'd1; want[1] = 32'd2; want[2] = 32'd3;
    drive_cycle(1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    vectors++;
    if (in_ready_o !== 1'b0 || state_dbg_o !== 2'd2 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL bp_full: got rdy=%b st=%0d want rdy=0 st=2", in_ready_o, state_dbg_o);
    end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL bp_stall_cnt: got stall=%0d want %0d", stall_cnt_o, stall_m);
      end
    end
    seen = 0;
    c_in = 1'b0;
    for (int cyc = 0; cyc < 12 && seen < 3; cyc++) begin
      if (out_valid_o === 1'b1) begin
        vectors++;
        if (result_o !== want[seen]) begin
          miscompares++;
          $display("FAIL bp_order: got %h want %h", result_o, want[seen]);
        end
        seen++;
      end
      if (!c_in && exp_q.size() < 2) begin
        c_in = 1'b1;
        drive_cycle(1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
      end else begin
        drive_cycle(c_in ? 1'b0 : 1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
      end
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL bp_drain_cycle: got %h want %h", obs, exp_vec());
      end
    end
    vectors++;
    if (seen != 3) begin
      miscompares++;
      $display("FAIL bp_timeout: got %0d beats want 3", seen);
    end
  endtask

  task automatic test_x_scrub;
    drive_cycle(1'b1, 32'h10, 1'bx, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    vectors++;
    if (jump_now_o !== 1'b0 || out_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL xscrub_x: got j=%b v=%b want j=0 v=1", jump_now_o, out_valid_o);
    end
    drive_cycle(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    vectors++;
    if (jump_now_o !== 1'b0) begin
      miscompares++;
      $display("FAIL xscrub_nobranch: got j=%b want j=0", jump_now_o);
    end
    drive_cycle(1'b1, 32'h12, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    vectors++;
    if (jump_now_o !== 1'b1 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL xscrub_branch: got j=%b want j=1", jump_now_o);
    end
    idle_cycle(1'b1);
  endtask

  task automatic test_r0;
    drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    vectors++;
    if (wen_o !== 1'b0 || result_o !== 32'hDEAD_BEEF || rd_addr_o !== 5'd0) begin
      miscompares++;
      $display("FAIL r0_suppress: got w=%b r=%h want w=0 r=deadbeef", wen_o, result_o);
    end
    idle_cycle(1'b1);
  endtask

  task automatic test_flush;
    drive_cycle(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    vectors++;
    if (state_dbg_o !== 2'd2) begin
      miscompares++;
      $display("FAIL flush_setup: got st=%0d want 2", state_dbg_o);
    end
    drive_cycle(1'b1, 32'h77, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1);
    vectors++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || result_o !== '0 ||
        jump_now_o !== 1'b0 || wen_o !== 1'b0 || rd_addr_o !== '0) begin
      miscompares++;
      $display("FAIL flush_clear: got v=%b rdy=%b r=%h want v=0 rdy=1 r=0",
               out_valid_o, in_ready_o, result_o);
    end
    for (int k = 0; k < 3; k++) begin
      idle_cycle(1'b1);
      vectors++;
      if (out_valid_o !== 1'b0 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL flush_ghost: got v=%b r=%h want v=0", out_valid_o, result_o);
      end
    end
  endtask

  task automatic test_reset_mid;
    // Bring stall count to exactly 5 and leave one beat held.
    n_reset = 1'b0;
    model_reset();
    #3;
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      drive_cycle(1'b1, 32'hB3, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    idle_cycle(1'b1);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    vectors++;
    if (stall_cnt_o !== 16'd5 || state_dbg_o !== 2'd1 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL rstmid_setup: got stall=%0d st=%0d want stall=5 st=1",
               stall_cnt_o, state_dbg_o);
    end
    #1;
    n_reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (out_valid_o !== 1'b0 || stall_cnt_o !== 16'd0 || in_ready_o !== 1'b1 ||
        obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL rstmid_async: got v=%b stall=%0d want v=0 stall=0",
               out_valid_o, stall_cnt_o);
    end
    #1;
    n_reset = 1'b1;
    drive_cycle(1'b1, 32'hC0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
    vectors++;
    if (out_valid_o !== 1'b1 || result_o !== 32'hC0) begin
      miscompares++;
      $display("FAIL rstmid_first_accept: got v=%b r=%h want v=1 r=c0",
               out_valid_o, result_o);
    end
    idle_cycle(1'b1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 600; k++) begin
      drive_cycle($urandom_range(0, 9) < 7, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31) & 5'h13),
                  $urandom_range(0, 9) < 5, $urandom_range(0, 29) == 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h want %h", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_x_scrub();
    test_r0();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exe_wb_pipe.md
EXE_WB_PIPE -- requirements
Module: exe_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, ALU result width.
REQ-002 SHALL have parameter RA_W, default 5, register-file address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port n_reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid_i  input  1  ALU beat presented.
REQ-006 SHALL have port in_ready_o  output  1  stage can accept a beat.
REQ-007 SHALL have port result_i  input  DATA_W  ALU result_o.
REQ-008 SHALL have port jump_now_i  input  1  ALU jump_now_o; may be X when is_branch_i=0.
REQ-009 SHALL have port is_branch_i  input  1  beat is a conditional branch.
REQ-010 SHALL have port wen_i  input  1  beat writes the register file.
REQ-011 SHALL have port rd_addr_i  input  RA_W  destination register.
REQ-012 SHALL have port flush_i  input  1  discard all held and incoming beats.
REQ-013 SHALL have port out_valid_o  output  1  head beat valid toward writeback.
REQ-014 SHALL have port out_ready_i  input  1  writeback accepts the head beat.
REQ-015 SHALL have ports result_o (DATA_W), jump_now_o (1), wen_o (1), rd_addr_o (RA_W), all outputs: head-beat fields.
REQ-016 SHALL have port stall_cnt_o  output  16  saturating upstream-stall counter.

Function
REQ-017 SHALL implement a 2-entry in-order skid buffer with states EMPTY, ONE, TWO.
REQ-018 SHALL accept a beat when in_valid_i && in_ready_o && !flush_i, and release a beat when out_valid_o && out_ready_i.
REQ-019 SHALL drive in_ready_o = (state != TWO), decoded from registered state only, with no combinational path from out_ready_i.
REQ-020 SHALL drive out_valid_o = (state != EMPTY).
REQ-021 SHALL transition EMPTY+accept->ONE; ONE+accept+!release->TWO; ONE+release+!accept->EMPTY; ONE+accept+release->ONE with the new beat as head; TWO+release->ONE with the tail promoted to head; otherwise hold.
REQ-022 SHALL capture jump_now as (is_branch_i & jump_now_i), so no X is ever stored or output for non-branch beats.
REQ-023 SHALL capture wen as (wen_i && rd_addr_i != 0), so register 0 is never written.
REQ-024 SHALL capture result_i and rd_addr_i unmodified, at full DATA_W/RA_W width.
REQ-025 SHALL drive result_o, jump_now_o, wen_o, rd_addr_o from the head entry when out_valid_o=1, and all of them 0 when EMPTY.
REQ-026 SHALL give latency of exactly 1 cycle from acceptance to out_valid_o in the EMPTY state.
REQ-027 SHALL, on flush_i=1, go to EMPTY at the next edge, drop any incoming beat that cycle, and clear both entries to 0; a release in the same cycle is still considered consumed by downstream.
REQ-028 SHALL increment stall_cnt_o on each cycle with in_valid_i && !in_ready_o, saturate at 16'hFFFF, and not clear on flush.
REQ-029 SHALL ensure beats leave in arrival order, with no duplication or loss except by flush.

Reset
REQ-030 SHALL, while n_reset=0 (asynchronously), force state EMPTY, clear both entries and stall_cnt_o to 0, and drive out_valid_o=0, in_ready_o=1, and all data outputs 0.
REQ-031 SHALL discard all held beats when reset is asserted mid-operation, and accept a beat on the first rising edge after deassertion.

Verification
REQ-032 SHALL verify single beat: EMPTY, in beat {result=32'h0000_00AA, wen=1, rd=3}, out_ready_i=1 -> next cycle out_valid_o=1, result_o=32'hAA, rd_addr_o=3, wen_o=1; the following cycle out_valid_o=0.
REQ-033 SHALL verify backpressure: out_ready_i=0, beats A=1 then B=2 -> state TWO, in_ready_o=0; third beat C held upstream increments stall_cnt_o by 1 per cycle; out_ready_i=1 -> outputs A, then B, then C, in order.
REQ-034 SHALL verify X-scrub: is_branch_i=0, jump_now_i=X -> jump_now_o=0; is_branch_i=1, jump_now_i=1 -> jump_now_o=1.
REQ-035 SHALL verify r0 suppression: wen_i=1, rd_addr_i=0, result_i=32'hDEAD_BEEF -> wen_o=0, result_o=32'hDEAD_BEEF.
REQ-036 SHALL verify flush: state TWO plus in_valid_i=1 and flush_i=1 -> next cycle out_valid_o=0, in_ready_o=1, all data outputs 0; the incoming beat never appears at the output.
REQ-037 SHALL verify reset: assert n_reset=0 mid-cycle while in state ONE with stall_cnt_o=5 -> immediately out_valid_o=0 and stall_cnt_o=0.
